vga_capture_rx: RTL and testbench

- Receive end of the VGA output interface: consumes hsync/vsync/blank_n and 24-bit RGB as driven by the display pipeline (or an external source on the same pixel clock).
- Recovers pixel coordinates and measures line and frame timing against the configured mode.
- Declares lock once timing is stable and re-emits the active pixels as a qualified stream with x/y tags.
- Used for loopback self-test of the VGA path and as the front end for a future frame-grabber.

---
 rtl/vga_capture_rx.sv | 192 +++++++++++++++++++
 tb/tb_vga_capture_rx.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture_rx.sv
// VGA receive front end: recovers sync edges, measures line/frame timing, locks, and re-emits active pixels tagged with x/y.
// Define VGA_CAPTURE_CHECKSUM_EN to add a per-frame RGB sum (frame_sum / frame_sum_valid).
module vga_capture_rx #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        locked,
  output logic        timing_err,
  output logic        frame_start,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic [10:0] h_meas,
  output logic [10:0] v_meas
`ifdef VGA_CAPTURE_CHECKSUM_EN
  ,
  output logic [31:0] frame_sum,
  output logic        frame_sum_valid
`endif
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [10:0] H_T   = 11'(H_TOTAL);
  localparam logic [10:0] V_T   = 11'(V_TOTAL);
  localparam logic [10:0] H_SAT = 11'(2 * H_TOTAL);
  localparam logic [2:0]  LK_N  = 3'(LOCK_FRAMES);

  state_t      r_state, w_state_n;
  logic [2:0]  r_good, w_good_n;
  logic        r_hs1, r_vs1, r_blank1, r_hs2, r_vs2;
  logic [23:0] r_rgb1;
  logic [10:0] r_hcnt, r_lcnt;
  logic [9:0]  r_xcnt, r_ycnt;
  logic        r_line_act, r_hbad;

  logic        w_hs_fall, w_vs_fall, w_sat, w_hbad_now, w_vbad_now, w_err, w_line_had, w_pv_n;
  logic [10:0] w_hlen;

  assign w_hs_fall  = r_hs2 & ~r_hs1;
  assign w_vs_fall  = r_vs2 & ~r_vs1;
  assign w_hlen     = r_hcnt + 11'd1;
  assign w_hbad_now = w_hs_fall && (w_hlen != H_T);
  assign w_vbad_now = w_vs_fall && (r_lcnt != V_T);
  // The clock that would carry hcnt onto its ceiling is the missing-hsync event; it fires once, then hcnt parks.
  assign w_sat      = !w_hs_fall && (r_hcnt == H_SAT - 11'd1);
  assign w_err      = (r_state == LOCKED) && (w_hbad_now || w_vbad_now || w_sat);
  assign w_line_had = r_line_act | r_blank1;
  assign w_pv_n     = r_blank1 && (w_state_n == LOCKED);
  assign locked     = (r_state == LOCKED);

  always_comb begin
    w_state_n = r_state;
    w_good_n  = r_good;
    case (r_state)
      SEARCH: begin
        if (w_vs_fall && !w_sat) begin
          w_state_n = MEASURE;
          w_good_n  = 3'd0;
        end
      end
      MEASURE: begin
        if (w_sat) begin
          w_state_n = SEARCH;
        end else if (w_vs_fall) begin
          // The line closed by a coincident hs_fall still belongs to the frame being judged.
          if (r_hbad || w_hbad_now || w_vbad_now) begin
            w_good_n = 3'd0;
          end else if (r_good + 3'd1 == LK_N) begin
            w_state_n = LOCKED;
          end else begin
            w_good_n = r_good + 3'd1;
          end
        end
      end
      LOCKED: begin
        if (w_hbad_now || w_vbad_now || w_sat) w_state_n = SEARCH;
      end
      default: w_state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SEARCH;
      r_good  <= 3'd0;
    end else begin
      r_state <= w_state_n;
      r_good  <= w_good_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs1       <= 1'b1;
      r_vs1       <= 1'b1;
      r_hs2       <= 1'b1;
      r_vs2       <= 1'b1;
      r_blank1    <= 1'b0;
      r_rgb1      <= 24'd0;
      r_hcnt      <= 11'd0;
      r_lcnt      <= 11'd0;
      r_hbad      <= 1'b0;
      r_xcnt      <= 10'd0;
      r_ycnt      <= 10'd0;
      r_line_act  <= 1'b0;
      h_meas      <= 11'd0;
      v_meas      <= 11'd0;
      timing_err  <= 1'b0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_rgb     <= 24'd0;
    end else begin
      r_hs1    <= vga_hs;
      r_vs1    <= vga_vs;
      r_hs2    <= r_hs1;
      r_vs2    <= r_vs1;
      r_blank1 <= vga_blank_n;
      r_rgb1   <= {red, green, blue};

      if (w_hs_fall) begin
        h_meas <= w_hlen;
        r_hcnt <= 11'd0;
      end else if (r_hcnt != H_SAT) begin
        r_hcnt <= r_hcnt + 11'd1;
      end

      if (w_vs_fall) begin
        v_meas <= r_lcnt;
        r_lcnt <= {10'd0, w_hs_fall};
      end else if (w_hs_fall) begin
        r_lcnt <= r_lcnt + 11'd1;
      end

      r_hbad <= w_vs_fall ? 1'b0 : (r_hbad | w_hbad_now);

      if (r_blank1) begin
        pix_x   <= r_xcnt;
        pix_y   <= r_ycnt;
        pix_rgb <= r_rgb1;
      end
      if (w_hs_fall)     r_xcnt <= 10'd0;
      else if (r_blank1) r_xcnt <= r_xcnt + 10'd1;

      if (w_vs_fall) begin
        r_ycnt     <= 10'd0;
        r_line_act <= 1'b0;
      end else if (w_hs_fall) begin
        r_ycnt     <= r_ycnt + {9'd0, w_line_had};
        r_line_act <= 1'b0;
      end else begin
        r_line_act <= w_line_had;
      end

      pix_valid   <= w_pv_n;
      timing_err  <= w_err;
      frame_start <= w_vs_fall;
    end
  end

`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [31:0] r_acc;
  logic [9:0]  w_pix_sum;

  assign w_pix_sum = {2'b00, r_rgb1[23:16]} + {2'b00, r_rgb1[15:8]} + {2'b00, r_rgb1[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc           <= 32'd0;
      frame_sum       <= 32'd0;
      frame_sum_valid <= 1'b0;
    end else begin
      r_acc           <= w_vs_fall ? 32'd0 : r_acc + (w_pv_n ? {22'd0, w_pix_sum} : 32'd0);
      frame_sum_valid <= w_vs_fall && (r_state == LOCKED);
      if (w_vs_fall && (r_state == LOCKED)) frame_sum <= r_acc;
    end
  end
`endif

endmodule

// File: tb/tb_vga_capture_rx.sv
// Bench for vga_capture_rx: small video mode, timestamp-based reference model checked every cycle,
// plus scripted lock/error/reset scenarios and a randomized timing-disturbance phase.
module tb_vga_capture_rx;
  localparam int H = 40, V = 20, LK = 2;
  localparam int H_ACT = 24, V_ACT = 12, HS_B = 28, HS_E = 34, VS_L = 15;
  localparam int M_SRCH = 0, M_MEAS = 1, M_LOCK = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_hs, vga_vs, vga_blank_n;
  logic [7:0]  red, green, blue;
  logic        locked, timing_err, frame_start, pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_rgb;
  logic [10:0] h_meas, v_meas;
`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [31:0] frame_sum;
  logic        frame_sum_valid;
`endif

  vga_capture_rx #(.H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(LK)) dut (
    .clk(clk), .reset(rst), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .red(red), .green(green), .blue(blue),
    .locked(locked), .timing_err(timing_err), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .h_meas(h_meas), .v_meas(v_meas)
`ifdef VGA_CAPTURE_CHECKSUM_EN
    , .frame_sum(frame_sum), .frame_sum_valid(frame_sum_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- generator ----------------
  int gx = 0, gy = 0;
  bit hs_force = 0, stretch = 0, skip = 0, rand_col = 0;
  logic [23:0] const_col = 24'h102030;
  int n_terr_obs = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (timing_err) n_terr_obs++;
    vga_blank_n = (gx < H_ACT) && (gy < V_ACT);
    vga_hs = hs_force ? 1'b1 : !((gx >= HS_B) && (gx < HS_E));
    vga_vs = !(((gy == VS_L) && (gx >= HS_B)) || (gy == VS_L + 1) || ((gy == VS_L + 2) && (gx < HS_B)));
    if (rand_col) {red, green, blue} = 24'($urandom);
    else          {red, green, blue} = const_col;
    if (stretch && gx == 30) begin
      stretch = 0;
    end else begin
      gx++;
      if (gx == H) begin
        gx = 0;
        gy++;
        if (skip && gy == 13) begin
          gy = 14;
          skip = 0;
        end
        if (gy == V) gy = 0;
      end
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  int m_step, m_last_fall, m_lines, m_col, m_rows, m_mode, m_good;
  bit m_line_had, m_fbad;
  bit s_hs, s_vs, s_bl, p_hs, p_vs;
  logic [23:0] s_rgb;
  int e_hm, e_vm, e_x, e_y;
  bit e_locked, e_terr, e_fs, e_pv;
  logic [23:0] e_rgb;
  logic [31:0] m_acc, e_fsum;
  bit e_fsv;

  task automatic model_reset();
    m_step = 0; m_last_fall = -1; m_lines = 0; m_col = 0; m_rows = 0;
    m_mode = M_SRCH; m_good = 0; m_line_had = 0; m_fbad = 0;
    s_hs = 1; s_vs = 1; s_bl = 0; s_rgb = '0; p_hs = 1; p_vs = 1;
    e_hm = 0; e_vm = 0; e_x = 0; e_y = 0; e_rgb = '0;
    e_locked = 0; e_terr = 0; e_fs = 0; e_pv = 0;
    m_acc = '0; e_fsum = '0; e_fsv = 0;
  endtask

  task automatic model_step();
    bit hf, vf, sat, hb, vb;
    int hc, pre_mode;
    hf = p_hs && !s_hs;
    vf = p_vs && !s_vs;
    // clocks elapsed since the last hsync fall, clamped at the 2*H ceiling
    hc = m_step - m_last_fall - 1;
    if (hc > 2 * H) hc = 2 * H;
    sat = !hf && (hc == 2 * H - 1);
    hb = hf && (hc + 1 != H);
    vb = vf && (m_lines != V);
    pre_mode = m_mode;
    e_terr = 0;
    if (m_mode == M_LOCK) begin
      if (hb || vb || sat) begin m_mode = M_SRCH; e_terr = 1; end
    end else if (sat) begin
      m_mode = M_SRCH;
    end else if (m_mode == M_SRCH) begin
      if (vf) begin m_mode = M_MEAS; m_good = 0; end
    end else if (vf) begin
      if (m_fbad || hb || vb) m_good = 0;
      else begin
        m_good++;
        if (m_good == LK) m_mode = M_LOCK;
      end
    end
    m_fbad = vf ? 0 : (m_fbad | hb);
    if (hf) begin e_hm = hc + 1; m_last_fall = m_step; end
    if (vf) begin e_vm = m_lines % 2048; m_lines = hf ? 1 : 0; end
    else if (hf) m_lines++;
    e_fs = vf;
    e_locked = (m_mode == M_LOCK);
    e_pv = s_bl && (m_mode == M_LOCK);
    if (s_bl) begin e_x = m_col % 1024; e_y = m_rows % 1024; e_rgb = s_rgb; end
    if (vf) begin m_rows = 0; m_line_had = 0; end
    else if (hf) begin if (m_line_had || s_bl) m_rows++; m_line_had = 0; end
    else m_line_had = m_line_had || s_bl;
    if (hf) m_col = 0; else if (s_bl) m_col++;
    if (vf) begin
      e_fsv = (pre_mode == M_LOCK);
      if (pre_mode == M_LOCK) e_fsum = m_acc;
      m_acc = '0;
    end else begin
      e_fsv = 0;
      if (e_pv) m_acc = m_acc + 32'(s_rgb[23:16]) + 32'(s_rgb[15:8]) + 32'(s_rgb[7:0]);
    end
    p_hs = s_hs;
    p_vs = s_vs;
    m_step++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      chk("locked", locked, e_locked);
      chk("timing_err", timing_err, e_terr);
      chk("frame_start", frame_start, e_fs);
      chk("pix_valid", pix_valid, e_pv);
      chk("h_meas", h_meas, e_hm);
      chk("v_meas", v_meas, e_vm);
      if (e_pv || rst) begin
        chk("pix_x", pix_x, e_x);
        chk("pix_y", pix_y, e_y);
        chk("pix_rgb", pix_rgb, e_rgb);
      end
`ifdef VGA_CAPTURE_CHECKSUM_EN
      chk("frame_sum_valid", frame_sum_valid, e_fsv);
      chk("frame_sum", frame_sum, e_fsum);
`endif
      if (!rst) begin
        model_step();
        s_hs = vga_hs; s_vs = vga_vs; s_bl = vga_blank_n; s_rgb = {red, green, blue};
      end
    end
  end

  // ---------------- scenario helpers ----------------
  task automatic wait_lock(output int nfs);
    nfs = 0;
    for (int i = 0; i < 6000; i++) begin
      step();
      if (frame_start) nfs++;
      if (locked) return;
    end
    nfs = -1;
  endtask

  task automatic wait_fs(input string nm);
    for (int i = 0; i < 2 * H * V; i++) begin
      step();
      if (frame_start) return;
    end
    chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic goto_pos(input int yy, input int xx);
    for (int i = 0; i < 2 * H * V; i++) begin
      if (gy == yy && gx == xx) return;
      step();
    end
    chk("goto_pos_timeout", 0, 1);
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_locked"}, locked, 0);
    chk({nm, "_pix_valid"}, pix_valid, 0);
    chk({nm, "_timing_err"}, timing_err, 0);
    chk({nm, "_frame_start"}, frame_start, 0);
    chk({nm, "_h_meas"}, h_meas, 0);
    chk({nm, "_v_meas"}, v_meas, 0);
    chk({nm, "_pix_x"}, pix_x, 0);
    chk({nm, "_pix_rgb"}, pix_rgb, 0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int nfs, t0, npix, maxx, maxy, badrgb, hm_at_err, force_left;
    bit seen_err;
    rst = 1;
    vga_hs = 1; vga_vs = 1; vga_blank_n = 0; red = 0; green = 0; blue = 0;
    repeat (3) step();
    reset_checks("por");
    rst = 0;

    // lock on a constant-colour stream, then audit one full locked frame
    wait_lock(nfs);
    chk("lock_fs_count_initial", nfs, 3);
    npix = 0; maxx = 0; maxy = 0; badrgb = 0;
    for (int i = 0; i < 2 * H * V; i++) begin
      step();
      if (pix_valid) begin
        npix++;
        if (int'(pix_x) > maxx) maxx = int'(pix_x);
        if (int'(pix_y) > maxy) maxy = int'(pix_y);
        if (pix_rgb != 24'h102030) badrgb++;
      end
      if (frame_start) break;
    end
    chk("frame_pix_count", npix, H_ACT * V_ACT);
    chk("frame_max_x", maxx, H_ACT - 1);
    chk("frame_max_y", maxy, V_ACT - 1);
    chk("frame_bad_rgb", badrgb, 0);
    rand_col = 1;

    // one line stretched by a clock while locked
    goto_pos(5, 0);
    stretch = 1;
    t0 = n_terr_obs; seen_err = 0; hm_at_err = 0;
    for (int i = 0; i < 2 * H; i++) begin
      step();
      if (timing_err && !seen_err) begin seen_err = 1; hm_at_err = int'(h_meas); end
    end
    chk("stretch_terr_pulses", n_terr_obs - t0, 1);
    chk("stretch_h_meas", hm_at_err, H + 1);
    chk("stretch_locked", locked, 0);
    wait_lock(nfs);
    chk("lock_fs_count_after_stretch", nfs, 3);

    // hsync held high long enough to saturate the line counter
    goto_pos(3, 0);
    hs_force = 1;
    t0 = n_terr_obs;
    repeat (100) step();
    hs_force = 0;
    chk("hold_terr_pulses", n_terr_obs - t0, 1);
    chk("hold_locked", locked, 0);
    wait_lock(nfs);
    chk("lock_fs_count_after_hold", nfs, 3);

    // one-cycle reset mid-line while locked
    goto_pos(4, 10);
    step();
    rst = 1;
    #1;
    reset_checks("midrst");
    step();
    rst = 0;

    // short frame while measuring must not lock nor flag an error
    t0 = n_terr_obs;
    wait_fs("first_fs");
    skip = 1;
    wait_fs("short_fs");
    chk("short_v_meas", v_meas, V - 1);
    chk("short_locked", locked, 0);
    wait_lock(nfs);
    chk("lock_fs_count_after_short", nfs, 2);
    chk("measure_terr_pulses", n_terr_obs - t0, 0);

`ifdef VGA_CAPTURE_CHECKSUM_EN
    rand_col = 0;
    const_col = 24'h010203;
    wait_fs("sum_fs");
    chk("sum_valid", frame_sum_valid, 1);
    chk("sum_value", frame_sum, H_ACT * V_ACT * 6);
    rand_col = 1;
`endif

    // randomized timing disturbances; the model judges every cycle
    force_left = 0;
    for (int i = 0; i < 9000; i++) begin
      if (force_left > 0) begin
        force_left--;
        hs_force = (force_left > 0);
      end else if (gx == 0 && $urandom_range(0, 299) == 0) begin
        hs_force = 1;
        force_left = $urandom_range(20, 120);
      end
      if (gx == 0 && !stretch && $urandom_range(0, 39) == 0) stretch = 1;
      if (gx == 0 && gy == 0 && $urandom_range(0, 3) == 0) skip = 1;
      step();
    end
    hs_force = 0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
